// File: rtl/icache_direct_if.sv
// Fetch-side and memory-side signal bundle for icache_direct.
// slave: the cache's view; master: the fetch stage / memory controller view.
interface icache_direct_if;
  logic        pc_valid_i;
  logic [31:0] pc_i;
  logic        jump_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic        busy_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ready_i;
  logic [31:0] mem_inst_i;

  modport slave (
    input  pc_valid_i, pc_i, jump_i, mem_ready_i, mem_inst_i,
    output inst_valid_o, inst_o, busy_o, mem_req_o, mem_addr_o
  );

  modport master (
    output pc_valid_i, pc_i, jump_i, mem_ready_i, mem_inst_i,
    input  inst_valid_o, inst_o, busy_o, mem_req_o, mem_addr_o
  );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped one-word-per-line instruction cache with single-word refill.
// Optional hit/miss counters are enabled by defining ICACHE_STATS_EN.
module icache_direct #(
  parameter int INDEX_WIDTH = 8,
  parameter int ADDR_USED   = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  icache_direct_if.slave    bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
`endif
);
  localparam int LINES = 1 << INDEX_WIDTH;
  localparam int TAG_W = ADDR_USED - INDEX_WIDTH - 2;

  typedef enum logic [1:0] {IDLE, REFILL, DELIVER} state_t;

  state_t                   state_q, state_d;
  logic [ADDR_USED-1:2]     miss_pc_q, miss_pc_d;
  logic                     drop_q, drop_d;
  logic                     inst_valid_q, inst_valid_d;
  logic [31:0]              inst_q;
  logic                     mem_req_q, mem_req_d;
  logic [31:0]              mem_addr_q, mem_addr_d;

  logic                     valid_q [LINES];
  logic [TAG_W-1:0]         tag_mem [LINES];
  logic [31:0]              data_mem [LINES];

  logic [INDEX_WIDTH-1:0]   req_idx, miss_idx;
  logic [TAG_W-1:0]         req_tag, miss_tag;
  logic                     req_io, miss_io, hit;
  logic                     hit_accept, miss_accept, fill_done, fill_we;
  logic                     unused_pc_bits;

  assign req_idx  = bus.pc_i[INDEX_WIDTH+1:2];
  assign req_tag  = bus.pc_i[ADDR_USED-1:INDEX_WIDTH+2];
  assign req_io   = (bus.pc_i[17:16] == 2'b11);
  assign miss_idx = miss_pc_q[INDEX_WIDTH+1:2];
  assign miss_tag = miss_pc_q[ADDR_USED-1:INDEX_WIDTH+2];
  assign miss_io  = (miss_pc_q[17:16] == 2'b11);
  assign unused_pc_bits = ^bus.pc_i[1:0];

  // I/O space never hits, so a stale line can never shadow a device read.
  assign hit = valid_q[req_idx] && (tag_mem[req_idx] == req_tag) && !req_io;

  always_comb begin
    state_d      = state_q;
    miss_pc_d    = miss_pc_q;
    drop_d       = drop_q;
    inst_valid_d = 1'b0;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    hit_accept   = 1'b0;
    miss_accept  = 1'b0;
    fill_done    = 1'b0;
    fill_we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.pc_valid_i && !bus.jump_i) begin
          if (hit) begin
            hit_accept   = 1'b1;
            inst_valid_d = 1'b1;
          end else begin
            miss_accept = 1'b1;
            miss_pc_d   = bus.pc_i[ADDR_USED-1:2];
            mem_req_d   = 1'b1;
            mem_addr_d  = {bus.pc_i[31:2], 2'b00};
            drop_d      = 1'b0;
            state_d     = REFILL;
          end
        end
      end
      REFILL: begin
        drop_d = drop_q | bus.jump_i;
        if (bus.mem_ready_i) begin
          fill_done = 1'b1;
          fill_we   = !miss_io;
          mem_req_d = 1'b0;
          state_d   = DELIVER;
        end
      end
      DELIVER: begin
        inst_valid_d = !drop_q;
        drop_d       = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      miss_pc_q    <= '0;
      drop_q       <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
    end else if (rdy) begin
      state_q      <= state_d;
      miss_pc_q    <= miss_pc_d;
      drop_q       <= drop_d;
      inst_valid_q <= inst_valid_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      if (hit_accept)
        inst_q <= data_mem[req_idx];
      else if (fill_done)
        inst_q <= bus.mem_inst_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && rdy && fill_we) begin
      data_mem[miss_idx] <= bus.mem_inst_i;
      tag_mem[miss_idx]  <= miss_tag;
    end
  end

  for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
    always_ff @(posedge clk) begin
      if (rst)
        valid_q[gi] <= 1'b0;
      else if (rdy && fill_we && (miss_idx == INDEX_WIDTH'(gi)))
        valid_q[gi] <= 1'b1;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (rdy) begin
      if (hit_accept)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_accept) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

  assign bus.inst_valid_o = inst_valid_q;
  assign bus.inst_o       = inst_q;
  assign bus.busy_o       = (state_q != IDLE);
  assign bus.mem_req_o    = mem_req_q;
  assign bus.mem_addr_o   = mem_addr_q;
endmodule

// File: tb/tb_icache_direct.sv
// Directed bench for icache_direct: hits, misses, aliasing, flush, rdy stall,
// I/O bypass and reset during refill.
module tb_icache_direct;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  int   checks = 0;
  int   errors = 0;

  icache_direct_if bus ();
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  icache_direct #(.INDEX_WIDTH(8), .ADDR_USED(18)) dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .bus        (bus.slave)
`ifdef ICACHE_STATS_EN
    ,
    .hit_cnt_o  (hit_cnt),
    .miss_cnt_o (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_hit(input logic [31:0] pc, input logic [31:0] word);
    bus.pc_valid_i = 1'b1;
    bus.pc_i       = pc;
    tick();
    check("hit_valid", bus.inst_valid_o, 32'd1);
    check("hit_inst", bus.inst_o, word);
    check("hit_no_req", bus.mem_req_o, 32'd0);
    bus.pc_valid_i = 1'b0;
    tick();
    check("hit_pulse_end", bus.inst_valid_o, 32'd0);
    $display("txn hit  pc=0x%08h inst=0x%08h", pc, bus.inst_o);
  endtask

  // Completes a refill already in REFILL: pulse mem_ready, then expect delivery.
  task automatic finish_refill(input logic [31:0] word, input logic expect_pulse);
    bus.mem_ready_i = 1'b1;
    bus.mem_inst_i  = word;
    tick();
    bus.mem_ready_i = 1'b0;
    bus.mem_inst_i  = 32'h0;
    check("fill_req_drop", bus.mem_req_o, 32'd0);
    check("fill_deliver_busy", bus.busy_o, 32'd1);
    check("fill_no_early", bus.inst_valid_o, 32'd0);
    tick();
    check("deliver_valid", bus.inst_valid_o, {31'd0, expect_pulse});
    if (expect_pulse) check("deliver_inst", bus.inst_o, word);
    check("deliver_idle", bus.busy_o, 32'd0);
    bus.pc_valid_i = 1'b0;
    tick();
    check("deliver_pulse_end", bus.inst_valid_o, 32'd0);
  endtask

  task automatic fetch_miss(input logic [31:0] pc, input logic [31:0] word, input int delay);
    bus.pc_valid_i = 1'b1;
    bus.pc_i       = pc;
    tick();
    check("miss_req", bus.mem_req_o, 32'd1);
    check("miss_addr", bus.mem_addr_o, {pc[31:2], 2'b00});
    check("miss_busy", bus.busy_o, 32'd1);
    for (int i = 0; i < delay; i++) begin
      tick();
      check("miss_hold_req", bus.mem_req_o, 32'd1);
      check("miss_hold_valid", bus.inst_valid_o, 32'd0);
    end
    finish_refill(word, 1'b1);
    $display("txn miss pc=0x%08h inst=0x%08h delay=%0d", pc, word, delay);
  endtask

  initial begin
    bus.pc_valid_i  = 1'b0;
    bus.pc_i        = 32'h0;
    bus.jump_i      = 1'b0;
    bus.mem_ready_i = 1'b0;
    bus.mem_inst_i  = 32'h0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_inst_valid", bus.inst_valid_o, 32'd0);
    check("rst_inst", bus.inst_o, 32'd0);
    check("rst_busy", bus.busy_o, 32'd0);
    check("rst_mem_req", bus.mem_req_o, 32'd0);
    check("rst_mem_addr", bus.mem_addr_o, 32'd0);

    // Cold miss, then hit on the same line
    fetch_miss(32'h0000_0000, 32'h0000_0013, 3);
    fetch_hit(32'h0000_0000, 32'h0000_0013);
`ifdef ICACHE_STATS_EN
    check("stats_hit1", hit_cnt, 32'd1);
    check("stats_miss1", miss_cnt, 32'd1);
`endif

    // 0x400 aliases index 0 and evicts it; 0x0 misses again
    fetch_miss(32'h0000_0400, 32'h0010_0093, 2);
    fetch_miss(32'h0000_0000, 32'h0000_0013, 1);

    // Flush mid-refill: no delivery but line still filled
    bus.pc_valid_i = 1'b1;
    bus.pc_i       = 32'h0000_1000;
    tick();
    check("jmp_req", bus.mem_req_o, 32'd1);
    check("jmp_addr", bus.mem_addr_o, 32'h0000_1000);
    bus.jump_i     = 1'b1;
    bus.pc_valid_i = 1'b0;
    tick();
    bus.jump_i = 1'b0;
    tick();
    finish_refill(32'h0020_0113, 1'b0);
    $display("txn miss pc=0x00001000 dropped by jump");
    fetch_hit(32'h0000_1000, 32'h0020_0113);

    // Jump in IDLE wins over a request that would hit
    bus.pc_valid_i = 1'b1;
    bus.jump_i     = 1'b1;
    bus.pc_i       = 32'h0000_1000;
    tick();
    bus.pc_valid_i = 1'b0;
    bus.jump_i     = 1'b0;
    check("jmp_idle_valid", bus.inst_valid_o, 32'd0);
    check("jmp_idle_busy", bus.busy_o, 32'd0);
    check("jmp_idle_req", bus.mem_req_o, 32'd0);
    $display("txn jump pc=0x00001000 ignored");

    // rdy low during refill freezes everything
    bus.pc_valid_i = 1'b1;
    bus.pc_i       = 32'h0000_2004;
    tick();
    check("rdy_req", bus.mem_req_o, 32'd1);
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rdy_hold_req", bus.mem_req_o, 32'd1);
      check("rdy_hold_addr", bus.mem_addr_o, 32'h0000_2004);
      check("rdy_hold_busy", bus.busy_o, 32'd1);
    end
    rdy = 1'b1;
    tick();
    finish_refill(32'h0030_0193, 1'b1);
    $display("txn miss pc=0x00002004 with rdy stall");
    fetch_hit(32'h0000_2004, 32'h0030_0193);

    // I/O space: always misses and does not disturb the cached line
    fetch_miss(32'h0003_0004, 32'hAAAA_0001, 1);
    fetch_miss(32'h0003_0004, 32'hAAAA_0002, 1);
    fetch_hit(32'h0000_2004, 32'h0030_0193);

    // Reset mid-refill; a late mem_ready must be ignored
    bus.pc_valid_i = 1'b1;
    bus.pc_i       = 32'h0003_0004;
    tick();
    check("rstmid_req", bus.mem_req_o, 32'd1);
    tick();
    rst            = 1'b1;
    bus.pc_valid_i = 1'b0;
    tick();
    rst = 1'b0;
    check("rstmid_busy", bus.busy_o, 32'd0);
    check("rstmid_req_clr", bus.mem_req_o, 32'd0);
    check("rstmid_addr_clr", bus.mem_addr_o, 32'd0);
    bus.mem_ready_i = 1'b1;
    bus.mem_inst_i  = 32'h0000_0055;
    tick();
    bus.mem_ready_i = 1'b0;
    bus.mem_inst_i  = 32'h0;
    check("late_ready_valid", bus.inst_valid_o, 32'd0);
    check("late_ready_busy", bus.busy_o, 32'd0);
    tick();
    check("late_ready_valid2", bus.inst_valid_o, 32'd0);
    $display("txn reset during refill, late mem_ready ignored");

    // Reset cleared all valid bits, so 0x0 misses
    fetch_miss(32'h0000_0000, 32'h0000_0013, 0);
`ifdef ICACHE_STATS_EN
    check("stats_hit_end", hit_cnt, 32'd0);
    check("stats_miss_end", miss_cnt, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped instruction cache between the PC/fetch stage and the memory controller's instruction port.
- Hits return the instruction word one cycle after the request.
- Misses issue a single word refill to the memory controller, write the word into the line, and return it.
- Flushes from taken branches or jumps discard any delivery still pending.

Parameters:
- INDEX_WIDTH, 8: number of index bits, giving 2^INDEX_WIDTH one-word lines.
- ADDR_USED, 18: number of low address bits that are significant (128KB RAM plus I/O space). Tag is pc[ADDR_USED-1:INDEX_WIDTH+2].

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global ready; low freezes all state
- pc_valid_i  in  1  fetch request; held high by the fetch stage until inst_valid_o
- pc_i  in  32  fetch address; pc_i[1:0] always 0
- jump_i  in  1  pipeline redirect; abandons any pending delivery
- inst_valid_o  out  1  one-cycle pulse; inst_o is valid for pc_i of the accepted request
- inst_o  out  32  instruction word
- busy_o  out  1  high while state is not IDLE
- mem_req_o  out  1  refill request to the memory controller
- mem_addr_o  out  32  refill word address, {pc[31:2],2'b00}
- mem_ready_i  in  1  one-cycle pulse; refill word valid on mem_inst_i
- mem_inst_i  in  32  refill word, little-endian assembled

Behaviour:
- Reset outputs: inst_valid_o=0, inst_o=0, busy_o=0, mem_req_o=0, mem_addr_o=0.
- Reset state: all valid bits cleared, state=IDLE.
- Reset mid-refill: go to IDLE immediately; any later mem_ready_i is ignored.
- rdy=0: no state, valid, tag, data or output register changes; outputs hold their values.
- States: IDLE, REFILL, DELIVER.
- IDLE, hit (pc_valid_i=1, jump_i=0, valid[idx]=1, tag match):
  - inst_o <= data[idx], inst_valid_o <= 1 on the next edge; stay in IDLE.
  - Back-to-back hits give one word per cycle.
- IDLE, miss (pc_valid_i=1, jump_i=0, line invalid or tag mismatch):
  - Latch the pc into miss_pc.
  - mem_req_o <= 1, mem_addr_o <= {pc_i[31:2],2'b00}.
  - Next state REFILL.
- IDLE with jump_i=1: the request is ignored that cycle; no output pulse. Jump wins over a simultaneous pc_valid_i.
- REFILL:
  - mem_req_o and mem_addr_o are held stable until mem_ready_i.
  - On mem_ready_i: data[idx] <= mem_inst_i, tag[idx] <= miss tag, valid[idx] <= 1, mem_req_o <= 0, next state DELIVER.
  - If jump_i was seen at any point in REFILL, a drop flag is set. The fill still completes and the line is written, but delivery is suppressed.
  - pc_valid_i is ignored while in REFILL.
- DELIVER:
  - If drop=0, inst_valid_o <= 1 with the refilled word.
  - drop is cleared; next state IDLE.
  - One-cycle state. Miss latency is refill latency + 2 cycles from request acceptance.
- jump_i in the same cycle as inst_valid_o=1: the fetch stage discards the word; the cache takes no action.
- inst_valid_o is never high for more than one consecutive cycle per accepted request.
- I/O addresses (pc[17:16]==2'b11) are never cached: always take the miss path and do not set valid.
- Index is pc[INDEX_WIDTH+1:2].
- Aliasing lines simply overwrite (direct-mapped); no write port and no coherence with stores.

Optional Feature:
- Macro ICACHE_STATS_EN adds outputs hit_cnt_o[31:0] and miss_cnt_o[31:0].
  - Both reset to 0 and freeze when rdy=0.
  - hit_cnt_o increments once per hit accepted in IDLE; miss_cnt_o once per transition into REFILL.
  - Both wrap modulo 2^32.
- Without the macro these ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- After reset, request pc=0x00000000; memory returns 0x00000013 after 3 cycles -> mem_req_o=1 with mem_addr_o=0x0; inst_valid_o pulses once with inst_o=0x00000013 two cycles after mem_ready_i; valid[0]=1.
- Re-request pc=0x0 -> inst_valid_o next cycle, inst_o=0x00000013, mem_req_o stays 0; with ICACHE_STATS_EN, hit_cnt_o=1 and miss_cnt_o=1.
- Request pc=0x400, which aliases index 0 with INDEX_WIDTH=8 -> miss, refill 0x00100093 replaces the line; a following pc=0x0 request misses again.
- Miss on pc=0x1000 with jump_i pulsed mid-refill -> no inst_valid_o; the line is still filled; a later pc=0x1000 request hits.
- rdy held low for 5 cycles during REFILL with mem_ready_i=0 -> mem_req_o and mem_addr_o unchanged; the fill completes normally after rdy returns high.
- Request pc=0x30004 twice -> two refills, no valid bit set; rst asserted mid-refill -> busy_o=0 and mem_req_o=0 after the edge, and a subsequent late mem_ready_i is ignored.
